// File: rtl/dled_pkg.sv
// Shared display-word field layout and arbiter state encoding for the
// seven-segment display path (arbiter and scan controller).
package dled_pkg;
    localparam int unsigned DLED_EN_BIT  = 0;
    localparam int unsigned DLED_DIG_LSB = 1;
    localparam int unsigned DLED_DIG_MSB = 24;
    localparam int unsigned DLED_DIG_W   = 24;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } dled_state_t;
endpackage

// File: rtl/dled_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1
// (mod NREQ), returned both one-hot and as an index.
module dled_rr_pick #(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [2:0]      i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [2:0]      o_idx,
    output logic            o_valid
);
    int unsigned w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = (32'(i_last) + k) % NREQ;
            // Inner scan keeps every i_req select at a constant index.
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!o_valid && (j == w_cand) && i_req[j]) begin
                    o_valid  = 1'b1;
                    o_gnt[j] = 1'b1;
                    o_idx    = 3'(j);
                end
            end
        end
    end
endmodule

// File: rtl/dled_arbiter.sv
// Round-robin owner of the six-digit display with minimum/maximum hold,
// producing the registered display control word.
module dled_arbiter
    import dled_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned MIN_HOLD = 50000,
    parameter int unsigned MAX_HOLD = 5000000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      upd,
    input  logic [24*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [2:0]           owner,
    output logic [31:0]          dled_reg
);
    localparam int unsigned    CW     = $clog2(MAX_HOLD);
    localparam logic [CW-1:0]  MIN_M1 = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0]  MAX_M1 = CW'(MAX_HOLD - 1);

    dled_state_t              r_state, w_state_nxt;
    logic [CW-1:0]            r_cnt, w_cnt_nxt;
    logic [2:0]               r_last, w_last_nxt;
    logic [2:0]               r_owner, w_owner_nxt;
    logic [NREQ-1:0]          r_gnt, w_gnt_nxt;
    logic [31:0]              r_dled, w_dled_nxt;

    logic [NREQ-1:0]          w_pick_oh;
    logic [2:0]               w_pick_idx;
    logic                     w_pick_valid;
    logic [DLED_DIG_W-1:0]    w_own_data, w_win_data;
    logic                     w_own_req, w_others, w_rel;

    dled_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_gnt   (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_own_data = '0;
        w_win_data = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (r_owner == 3'(j))    w_own_data = wdata[DLED_DIG_W*j +: DLED_DIG_W];
            if (w_pick_idx == 3'(j)) w_win_data = wdata[DLED_DIG_W*j +: DLED_DIG_W];
        end
    end

    // r_gnt is one-hot on the owner, so it doubles as the owner mask.
    assign w_own_req = |(req & r_gnt);
    assign w_others  = |(req & ~r_gnt);
    assign w_rel     = (!w_own_req && (r_cnt >= MIN_M1)) ||
                       ((r_cnt == MAX_M1) && w_others);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_gnt_nxt   = r_gnt;
        w_dled_nxt  = r_dled;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = OWN;
                    w_gnt_nxt   = w_pick_oh;
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_dled_nxt  = '0;
                    w_dled_nxt[DLED_DIG_MSB:DLED_DIG_LSB] = w_win_data;
                    w_dled_nxt[DLED_EN_BIT] = 1'b1;
                end
            end
            OWN: begin
                if (w_rel) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_owner_nxt = '0;
                    w_dled_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                end else begin
                    w_cnt_nxt = (r_cnt == MAX_M1) ? r_cnt : r_cnt + 1'b1;
                    if (|(upd & r_gnt))
                        w_dled_nxt[DLED_DIG_MSB:DLED_DIG_LSB] = w_own_data;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_owner_nxt = '0;
                w_dled_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 3'(NREQ - 1);
            r_owner <= '0;
            r_gnt   <= '0;
            r_dled  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
            r_gnt   <= w_gnt_nxt;
            r_dled  <= w_dled_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign owner    = r_owner;
    assign dled_reg = r_dled;
endmodule

// File: tb/tb_dled_arbiter.sv
// Self-checking bench for dled_arbiter: directed scenarios plus random
// traffic, compared each cycle against an ownership-level reference model.
module tb_dled_arbiter;
    localparam int NREQ     = 3;
    localparam int MIN_HOLD = 4;
    localparam int MAX_HOLD = 16;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic [2:0]  req   = '0;
    logic [2:0]  upd   = '0;
    logic [71:0] wdata = '0;
    logic [2:0]  gnt;
    logic [2:0]  owner;
    logic [31:0] dled_reg;

    dled_arbiter #(.NREQ(NREQ), .MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .upd      (upd),
        .wdata    (wdata),
        .gnt      (gnt),
        .owner    (owner),
        .dled_reg (dled_reg)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    // Reference: m_owner < 0 means nobody holds the display; m_age counts
    // completed cycles of the current tenure (unbounded, no saturation).
    int          m_owner = -1;
    int          m_last  = NREQ - 1;
    int          m_age   = 0;
    logic [31:0] m_disp  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] digits(input int w);
        return 24'(wdata >> (24 * w));
    endfunction

    function automatic logic bit_of(input logic [2:0] v, input int w);
        logic [2:0] t;
        t = v >> w;
        return t[0];
    endfunction

    task automatic model_edge();
        logic others;
        int   w;
        if (!rstn) begin
            m_owner = -1; m_last = NREQ - 1; m_age = 0; m_disp = '0;
        end else if (m_owner < 0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && bit_of(req, (m_last + k) % NREQ)) w = (m_last + k) % NREQ;
            if (w >= 0) begin
                m_owner = w;
                m_age   = 0;
                m_disp  = {7'b0, digits(w), 1'b1};
            end
        end else begin
            others = 1'b0;
            for (int i = 0; i < NREQ; i++)
                if (i != m_owner && bit_of(req, i)) others = 1'b1;
            if ((!bit_of(req, m_owner) && m_age >= MIN_HOLD - 1) ||
                (m_age >= MAX_HOLD - 1 && others)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_disp  = '0;
            end else begin
                m_age++;
                if (bit_of(upd, m_owner)) m_disp[24:1] = digits(m_owner);
            end
        end
    endtask

    task automatic step();
        logic [31:0] eg, eo;
        @(posedge clk);
        model_edge();
        #1;
        eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        eo = (m_owner < 0) ? 32'd0 : 32'(m_owner);
        chk("gnt", {29'b0, gnt}, eg);
        chk("owner", {29'b0, owner}, eo);
        chk("dled_reg", dled_reg, m_disp);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int hi;
        int seq[$];
        logic [2:0] prev_gnt;
        int first_owner;

        // 1: reset, first grant
        req = 3'b000; upd = '0; wdata = '0;
        do_reset();
        chk("t1_reset_dled", dled_reg, 32'h0);
        wdata[23:0] = 24'h123456;
        req = 3'b001;
        step();
        chk("t1_gnt", {29'b0, gnt}, 32'h1);
        chk("t1_dled", dled_reg, 32'h0024_68AD);

        // 2: owner update, concurrent non-owner update ignored
        wdata[23:0]  = 24'hABCDEF;
        wdata[47:24] = 24'h777777;
        upd = 3'b011;
        step();
        upd = '0;
        chk("t2_digits", {8'b0, dled_reg[24:1]}, 32'h00AB_CDEF);

        // 3: owner drops req early -> exactly MIN_HOLD cycles of gnt
        req = 3'b000;
        hi = 2;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gnt != 3'b000) hi++;
            else break;
        end
        chk("t3_hold", 32'(hi), 32'(MIN_HOLD));
        chk("t3_blank", dled_reg, 32'h0);

        // 4: all requesting -> 0,1,2,0 each MAX_HOLD cycles
        do_reset();
        req = 3'b111;
        prev_gnt = '0;
        for (int i = 0; i < 4 * (MAX_HOLD + 1); i++) begin
            wdata = {$urandom, $urandom, $urandom} >> 24;
            upd = 3'($urandom);
            step();
            if (prev_gnt == 3'b000 && gnt != 3'b000) seq.push_back(int'(owner));
            prev_gnt = gnt;
        end
        upd = '0;
        chk("t4_ngrants", 32'(seq.size()), 32'd4);
        for (int i = 0; i < 4 && i < seq.size(); i++)
            chk("t4_order", 32'(seq[i]), 32'(i % 3));

        // 5: reset mid-ownership at hold count 7
        do_reset();
        req = 3'b111;
        step();
        for (int i = 0; i < 7; i++) step();
        rstn = 1'b0;
        step();
        chk("t5_gnt", {29'b0, gnt}, 32'h0);
        chk("t5_dled", dled_reg, 32'h0);
        rstn = 1'b1;
        req = 3'b110;
        step();
        chk("t5_owner", {29'b0, owner}, 32'd1);

        // 6: update in the forced-release cycle is dropped
        do_reset();
        req = 3'b011;
        step();
        first_owner = int'(owner);
        for (int i = 0; i < 4 * MAX_HOLD && m_age < MAX_HOLD - 1; i++) step();
        chk("t6_reached", 32'(m_age), 32'(MAX_HOLD - 1));
        wdata = {$urandom, $urandom, $urandom} >> 24;
        upd = 3'b001;
        step();
        upd = '0;
        chk("t6_blank", dled_reg, 32'h0);
        step();
        chk("t6_next", {29'b0, owner}, 32'd1);
        chk("t6_first", 32'(first_owner), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req = 3'($urandom);
            upd   = 3'($urandom);
            wdata = {$urandom, $urandom, $urandom} >> 24;
            rstn  = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
